// File: rtl/pipe_stall_sink_if.sv
// Handshake bundle between the last upstream pipeff stage, the stall-generating sink
// and its valid/ready consumer.
interface pipe_stall_sink_if #(
  parameter int DATA = 32,
  parameter int SKID = 2
);
  localparam int CW = $clog2(SKID + 1);

  logic            in_valid;
  logic [DATA-1:0] in_data;
  logic            stall;
  logic            out_valid;
  logic [DATA-1:0] out_data;
  logic            out_ready;
  logic [CW-1:0]   count;

  modport slave (
    input  in_valid, in_data, out_ready,
    output stall, out_valid, out_data, count
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  stall, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_stall_sink.sv
// Pipeline sink: absorbs pipeff beats into a small circular FIFO and drives a purely
// registered stall back up the pipe, so out_ready never reaches stall combinationally.
module pipe_stall_sink #(
  parameter int DATA = 32,
  parameter int SKID = 2
) (
  input logic            clk,
  input logic            reset,
  input logic            flush,
  pipe_stall_sink_if.slave bus
);
  localparam int CW = $clog2(SKID + 1);
  localparam int PW = (SKID > 1) ? $clog2(SKID) : 1;

  logic [DATA-1:0] mem [SKID];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_next;
  logic            stall_q;
  logic            push;
  logic            pop;

  // Explicit wrap so depths that are not a power of two never index past the last entry.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(SKID - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    push       = bus.in_valid & ~stall_q;
    pop        = (count_q != '0) & bus.out_ready;
    count_next = count_q;
    if (push && !pop) begin
      count_next = count_q + 1'b1;
    end else if (pop && !push) begin
      count_next = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count_q <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      stall_q <= 1'b0;
    end else begin
      count_q <= count_next;
      stall_q <= (count_next == CW'(SKID));
      if (push) begin
        wr_ptr <= bump(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= bump(rd_ptr);
      end
    end
  end

  // Storage carries no reset; entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (push && !reset && !flush) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  assign bus.stall     = stall_q;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = mem[rd_ptr];
  assign bus.count     = count_q;

  a_count_bound: assert property (@(posedge clk) disable iff (reset) count_q <= CW'(SKID));
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && count_q == CW'(SKID)));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(pop && count_q == '0));
endmodule

// File: tb/tb_pipe_stall_sink.sv
// Scoreboard bench for pipe_stall_sink at depths 2 and 3, with an emulated upstream
// pipeff that holds its beat while stalled.
module tb_pipe_stall_sink;
  logic clk;
  logic reset_a, flush_a, reset_b, flush_b;
  int   compared = 0;
  int   mismatched = 0;

  pipe_stall_sink_if #(.DATA(32), .SKID(2)) bus2 ();
  pipe_stall_sink_if #(.DATA(32), .SKID(3)) bus3 ();

  pipe_stall_sink #(.DATA(32), .SKID(2)) dut2 (.clk(clk), .reset(reset_a), .flush(flush_a), .bus(bus2));
  pipe_stall_sink #(.DATA(32), .SKID(3)) dut3 (.clk(clk), .reset(reset_b), .flush(flush_b), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference models, sampled on the falling edge while inputs are stable.
  logic [31:0] q2[$];
  logic [31:0] q3[$];
  int  mc2 = 0, mc3 = 0, rx2 = 0, rx3 = 0;
  bit  ms2 = 0, ms3 = 0, armed2 = 0, armed3 = 0;

  always @(negedge clk) begin
    bit push, pop;
    if (armed2) begin
      checkOutput("sb2_count", 32'(bus2.count), 32'(mc2));
      checkOutput("sb2_stall", 32'(bus2.stall), 32'(ms2));
      checkOutput("sb2_valid", 32'(bus2.out_valid), 32'(mc2 != 0));
    end
    if (reset_a || flush_a) begin
      q2.delete();
      armed2 = 1;
    end else if (armed2) begin
      push = bus2.in_valid && !ms2;
      pop  = (mc2 != 0) && bus2.out_ready;
      if (pop) begin
        checkOutput("sb2_data", bus2.out_data, q2[0]);
        void'(q2.pop_front());
        rx2++;
      end
      if (push) q2.push_back(bus2.in_data);
    end
    mc2 = q2.size();
    ms2 = (mc2 == 2);
  end

  always @(negedge clk) begin
    bit push, pop;
    if (armed3) begin
      checkOutput("sb3_count", 32'(bus3.count), 32'(mc3));
      checkOutput("sb3_stall", 32'(bus3.stall), 32'(ms3));
      checkOutput("sb3_valid", 32'(bus3.out_valid), 32'(mc3 != 0));
    end
    if (reset_b || flush_b) begin
      q3.delete();
      armed3 = 1;
    end else if (armed3) begin
      push = bus3.in_valid && !ms3;
      pop  = (mc3 != 0) && bus3.out_ready;
      if (pop) begin
        checkOutput("sb3_data", bus3.out_data, q3[0]);
        void'(q3.pop_front());
        rx3++;
      end
      if (push) q3.push_back(bus3.in_data);
    end
    mc3 = q3.size();
    ms3 = (mc3 == 3);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat and holds it until an edge with stall low accepts it.
  task automatic applyStimulus(input bit sel, input logic [31:0] data, input bit rnd);
    bit st;
    int guard = 0;
    if (sel) begin bus3.in_valid = 1'b1; bus3.in_data = data; end
    else begin bus2.in_valid = 1'b1; bus2.in_data = data; end
    do begin
      if (rnd) bus3.out_ready = 1'($urandom_range(0, 1));
      st = sel ? bus3.stall : bus2.stall;
      tick();
      guard++;
    end while (st && guard < 50);
    if (st) checkOutput("send_timeout", 32'(guard), 32'd0);
  endtask

  initial begin
    reset_a = 1; reset_b = 1; flush_a = 0; flush_b = 0;
    bus2.in_valid = 0; bus2.in_data = '0; bus2.out_ready = 0;
    bus3.in_valid = 0; bus3.in_data = '0; bus3.out_ready = 0;
    tick(); tick();
    reset_a = 0; reset_b = 0;
    checkOutput("rst_count", 32'(bus2.count), 0);
    checkOutput("rst_stall", 32'(bus2.stall), 0);
    checkOutput("rst_valid", 32'(bus2.out_valid), 0);

    // Streaming at full rate: each beat appears the cycle after its push.
    bus2.out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 32'(i), 0);
      checkOutput("t1_data", bus2.out_data, 32'(i));
      checkOutput("t1_count", 32'(bus2.count), 1);
      checkOutput("t1_stall", 32'(bus2.stall), 0);
    end
    bus2.in_valid = 0;
    tick();
    checkOutput("t1_empty", 32'(bus2.out_valid), 0);

    // Fill with A,B then hold C against a full FIFO.
    bus2.out_ready = 0;
    applyStimulus(0, 32'hA, 0);
    applyStimulus(0, 32'hB, 0);
    checkOutput("t2_count", 32'(bus2.count), 2);
    checkOutput("t2_stall", 32'(bus2.stall), 1);
    bus2.in_data = 32'hC;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t2_hold", 32'(bus2.count), 2);
    end

    // Drain: A leaves, stall releases, held C enters exactly once.
    bus2.out_ready = 1;
    tick();
    checkOutput("t3_stall", 32'(bus2.stall), 0);
    checkOutput("t3_headB", bus2.out_data, 32'hB);
    tick();
    bus2.in_valid = 0;
    checkOutput("t3_headC", bus2.out_data, 32'hC);
    checkOutput("t3_count", 32'(bus2.count), 1);
    tick();
    checkOutput("t3_empty", 32'(bus2.out_valid), 0);
    checkOutput("t3_rx", 32'(rx2), 11);

    // Push and pop on the same edge with one entry resident.
    bus2.out_ready = 0;
    applyStimulus(0, 32'h40, 0);
    bus2.out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 32'h41 + 32'(k), 0);
      checkOutput("t4_count", 32'(bus2.count), 1);
      checkOutput("t4_data", bus2.out_data, 32'h41 + 32'(k));
    end
    bus2.in_valid = 0;
    tick(); tick();

    // Depth 3 with random back-pressure exercises pointer wrap at a non-power-of-2.
    for (int i = 0; i < 10; i++) applyStimulus(1, 32'h50 + 32'(i), 1);
    bus3.in_valid = 0;
    bus3.out_ready = 1;
    for (int i = 0; i < 6; i++) tick();
    checkOutput("t5_rx", 32'(rx3), 10);
    checkOutput("t5_empty", 32'(bus3.count), 0);

    // Flush and then reset while full with a beat offered.
    for (int pass = 0; pass < 2; pass++) begin
      bus2.out_ready = 0;
      applyStimulus(0, 32'h60, 0);
      applyStimulus(0, 32'h61, 0);
      checkOutput("t6_full", 32'(bus2.stall), 1);
      bus2.in_data = 32'h62;
      if (pass == 0) flush_a = 1; else reset_a = 1;
      tick();
      flush_a = 0; reset_a = 0; bus2.in_valid = 0;
      checkOutput("t6_count", 32'(bus2.count), 0);
      checkOutput("t6_stall", 32'(bus2.stall), 0);
      checkOutput("t6_valid", 32'(bus2.out_valid), 0);
      tick();
    end

    // Normal operation resumes after the clear.
    bus2.out_ready = 1;
    applyStimulus(0, 32'h70, 0);
    checkOutput("t6_resume", bus2.out_data, 32'h70);
    bus2.in_valid = 0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
